adc_peak_sampler: RTL and testbench

//  Parametrised multi-channel controller for simultaneous-sampling serial ADCs of the LTC2320 family.
//  - Drives CNV and SCK from a single clock domain.
//  - Deserialises NUM_CH parallel SDO lanes and reports every sample.
//  - Tracks a per-channel peak over a window of WINDOW_CONV conversions.
//  - Sits between the ADC pins and the measurement/reporting logic.

---
 rtl/adc_ctrl_pkg.sv | 28 ++
 rtl/adc_lane_rx.sv | 104 ++++++++++
 rtl/adc_peak_sampler.sv | 158 +++++++++++++++
 tb/tb_adc_peak_sampler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared FSM state type, width constants and the peak-compare helper for adc_peak_sampler.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        WAIT,
        SHIFT,
        UPDATE
    } adc_state_t;

    // Widest supported conversion; lanes extend samples to this width so one compare serves every DATA_W.
    localparam int MAX_DATA_W = 24;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic gt(input logic [MAX_DATA_W-1:0] a,
                                input logic [MAX_DATA_W-1:0] b,
                                input logic                  signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage

// File: rtl/adc_lane_rx.sv
// One SDO lane: MSB-first deserialiser, sample register and windowed peak accumulator(s).
// Min tracking is built only when ADC_PEAK_MIN_EN is defined.
module adc_lane_rx
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdo,
    input  logic              capture,
    input  logic              update,
    input  logic              load_first,
    input  logic              publish,
    input  logic              clear,
    output logic [DATA_W-1:0] sample,
`ifdef ADC_PEAK_MIN_EN
    output logic [DATA_W-1:0] peak_min,
`endif
    output logic [DATA_W-1:0] peak_max
);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] max_q, max_d, peak_max_q, peak_max_d, new_max;
`ifdef ADC_PEAK_MIN_EN
    logic [DATA_W-1:0] min_q, min_d, peak_min_q, peak_min_d, new_min;
`endif

    function automatic logic [MAX_DATA_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED_MODE) begin
            return MAX_DATA_W'($signed(v));
        end
        return MAX_DATA_W'(v);
    endfunction

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
        shift_d    = shift_q;
        sample_d   = sample_q;
        max_d      = max_q;
        peak_max_d = peak_max_q;
        new_max    = (load_first || gt(ext(shift_q), ext(max_q), SIGNED_MODE)) ? shift_q : max_q;
`ifdef ADC_PEAK_MIN_EN
        min_d      = min_q;
        peak_min_d = peak_min_q;
        new_min    = (load_first || gt(ext(min_q), ext(shift_q), SIGNED_MODE)) ? shift_q : min_q;
`endif
        if (capture) begin
            shift_d = {shift_q[DATA_W-2:0], sdo};
        end
        if (update) begin
            sample_d = shift_q;
            max_d    = new_max;
            if (publish) begin
                peak_max_d = new_max;
            end
`ifdef ADC_PEAK_MIN_EN
            min_d = new_min;
            if (publish) begin
                peak_min_d = new_min;
            end
`endif
        end
        if (clear) begin
            max_d = '0;
`ifdef ADC_PEAK_MIN_EN
            min_d = '0;
`endif
        end
    end

    // NOTE: accumulators are cleared by the async reset too, so a mid-frame reset leaves no stale window state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
            shift_q    <= '0;
            sample_q   <= '0;
            max_q      <= '0;
            peak_max_q <= '0;
`ifdef ADC_PEAK_MIN_EN
            min_q      <= '0;
            peak_min_q <= '0;
`endif
        end else begin
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            max_q      <= max_d;
            peak_max_q <= peak_max_d;
`ifdef ADC_PEAK_MIN_EN
            min_q      <= min_d;
            peak_min_q <= peak_min_d;
`endif
        end
    end

    assign sample   = sample_q;
    assign peak_max = peak_max_q;
`ifdef ADC_PEAK_MIN_EN
    assign peak_min = peak_min_q;
`endif

endmodule

// File: rtl/adc_peak_sampler.sv
// CNV/SCK sequencer for LTC2320-style simultaneous-sampling ADCs with per-channel windowed peaks.
// Define ADC_PEAK_MIN_EN to add the PEAK_MIN output and per-lane minimum tracking.
module adc_peak_sampler
    import adc_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 16,
    parameter int CNV_CYCLES  = 10,
    parameter int CONV_CYCLES = 15,
    parameter int WINDOW_CONV = 1000,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PERFORM,
    input  logic [NUM_CH-1:0]        SDO,
    output logic                     CNV,
    output logic                     SCK,
    output logic [NUM_CH*DATA_W-1:0] SAMPLE,
    output logic                     SAMPLE_VALID,
    output logic [NUM_CH*DATA_W-1:0] PEAK_MAX,
    output logic                     PEAK_VALID,
`ifdef ADC_PEAK_MIN_EN
    output logic [NUM_CH*DATA_W-1:0] PEAK_MIN,
`endif
    output logic                     BUSY
);

    localparam int CNT_W = $clog2(max_of(max_of(CNV_CYCLES, CONV_CYCLES), 2 * DATA_W)) + 1;
    localparam int WIN_W = $clog2(WINDOW_CONV) + 1;

    localparam logic [CNT_W-1:0] CNV_LAST   = CNT_W'(CNV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * DATA_W - 1);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CONV - 1);

    adc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             cnv_q, cnv_d, sck_q, sck_d, busy_q, busy_d;
    logic             sample_valid_q, sample_valid_d, peak_valid_q, peak_valid_d;
    logic             capture, update, load_first, publish, clear;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 1'b1;
        win_d          = win_q;
        sample_valid_d = 1'b0;
        peak_valid_d   = 1'b0;
        capture        = 1'b0;
        update         = 1'b0;
        load_first     = 1'b0;
        publish        = 1'b0;
        clear          = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (PERFORM) state_d = CONVERT;
            end
            CONVERT: begin
                if (cnt_q == CNV_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Even count = SCK low phase; the next edge raises SCK and samples SDO.
                capture = ~cnt_q[0];
                if (cnt_q == SHIFT_LAST) begin
                    state_d = UPDATE;
                    cnt_d   = '0;
                end
            end
            UPDATE: begin
                cnt_d          = '0;
                update         = 1'b1;
                sample_valid_d = 1'b1;
                load_first     = (win_q == '0);
                if (win_q == WIN_LAST) begin
                    publish      = 1'b1;
                    peak_valid_d = 1'b1;
                    win_d        = '0;
                end else begin
                    win_d = win_q + 1'b1;
                end
                if (PERFORM) begin
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                    clear   = 1'b1;
                    win_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        cnv_d  = (state_d == CONVERT);
        sck_d  = (state_d == SHIFT) && cnt_d[0];
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            win_q          <= '0;
            cnv_q          <= 1'b0;
            sck_q          <= 1'b0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            peak_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            win_q          <= win_d;
            cnv_q          <= cnv_d;
            sck_q          <= sck_d;
            busy_q         <= busy_d;
            sample_valid_q <= sample_valid_d;
            peak_valid_q   <= peak_valid_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        adc_lane_rx #(
            .DATA_W      (DATA_W),
            .SIGNED_MODE (SIGNED_MODE)
        ) u_lane (
            .clk        (CLK),
            .rst        (RST),
            .sdo        (SDO[i]),
            .capture    (capture),
            .update     (update),
            .load_first (load_first),
            .publish    (publish),
            .clear      (clear),
            .sample     (SAMPLE[i*DATA_W +: DATA_W]),
`ifdef ADC_PEAK_MIN_EN
            .peak_min   (PEAK_MIN[i*DATA_W +: DATA_W]),
`endif
            .peak_max   (PEAK_MAX[i*DATA_W +: DATA_W])
        );
    end

    assign CNV          = cnv_q;
    assign SCK          = sck_q;
    assign BUSY         = busy_q;
    assign SAMPLE_VALID = sample_valid_q;
    assign PEAK_VALID   = peak_valid_q;

endmodule

// File: tb/tb_adc_peak_sampler.sv
// Scoreboarded bench for adc_peak_sampler: a signed and an unsigned instance share one ADC lane model.
// Builds with or without ADC_PEAK_MIN_EN.
module tb_adc_peak_sampler;

    localparam int NUM_CH      = 8;
    localparam int DATA_W      = 16;
    localparam int CNV_CYCLES  = 10;
    localparam int CONV_CYCLES = 15;
    localparam int WINDOW_CONV = 4;
    localparam int W           = NUM_CH * DATA_W;

    typedef logic [W-1:0] word_t;
    typedef struct {
        word_t sample;
        bit    pv;
        word_t pmax_s;
        word_t pmin_s;
        word_t pmax_u;
        word_t pmin_u;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              PERFORM = 1'b0;
    logic [NUM_CH-1:0] SDO;
    logic              CNV, SCK, SAMPLE_VALID, PEAK_VALID, BUSY;
    word_t             SAMPLE, PEAK_MAX, PEAK_MIN;
    logic              u_cnv, u_sck, u_sample_valid, u_peak_valid, u_busy;
    word_t             u_sample, u_peak_max, u_peak_min;

    int checks   = 0;
    int failures = 0;
    int pv_count = 0;

    exp_t  exp_q[$];
    word_t drive_q[$];

    // Reference peak model: window position, running accumulators, last published values.
    int    win_n = 0;
    word_t acc_max_s = '0, acc_min_s = '0, acc_max_u = '0, acc_min_u = '0;
    word_t pub_max_s = '0, pub_min_s = '0, pub_max_u = '0, pub_min_u = '0;

    always #5 CLK = ~CLK;

    adc_peak_sampler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNV_CYCLES(CNV_CYCLES), .CONV_CYCLES(CONV_CYCLES),
        .WINDOW_CONV(WINDOW_CONV), .SIGNED_MODE(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .PERFORM(PERFORM), .SDO(SDO),
        .CNV(CNV), .SCK(SCK), .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID),
        .PEAK_MAX(PEAK_MAX), .PEAK_VALID(PEAK_VALID),
`ifdef ADC_PEAK_MIN_EN
        .PEAK_MIN(PEAK_MIN),
`endif
        .BUSY(BUSY)
    );

    adc_peak_sampler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNV_CYCLES(CNV_CYCLES), .CONV_CYCLES(CONV_CYCLES),
        .WINDOW_CONV(WINDOW_CONV), .SIGNED_MODE(1'b0)
    ) dut_u (
        .CLK(CLK), .RST(RST), .PERFORM(PERFORM), .SDO(SDO),
        .CNV(u_cnv), .SCK(u_sck), .SAMPLE(u_sample), .SAMPLE_VALID(u_sample_valid),
        .PEAK_MAX(u_peak_max), .PEAK_VALID(u_peak_valid),
`ifdef ADC_PEAK_MIN_EN
        .PEAK_MIN(u_peak_min),
`endif
        .BUSY(u_busy)
    );

`ifndef ADC_PEAK_MIN_EN
    assign PEAK_MIN   = '0;
    assign u_peak_min = '0;
`endif

    // ADC model: a new word per CNV rise, MSB presented first, next bit after each SCK rise.
    word_t cur_word = '0;
    int    bit_idx  = DATA_W - 1;

    always @(posedge CNV) begin
        cur_word = (drive_q.size() > 0) ? drive_q.pop_front() : '0;
        bit_idx  = DATA_W - 1;
    end

    always @(posedge SCK) begin
        #1;
        if (bit_idx > 0) bit_idx = bit_idx - 1;
    end

    always @* begin
        for (int i = 0; i < NUM_CH; i++) SDO[i] = cur_word[i*DATA_W + bit_idx];
    end

    function automatic void queue_frame(input word_t w);
        exp_t e;
        logic [DATA_W-1:0] v, ms, ns, mu, nu;
        drive_q.push_back(w);
        for (int c = 0; c < NUM_CH; c++) begin
            v  = w[c*DATA_W +: DATA_W];
            ms = acc_max_s[c*DATA_W +: DATA_W];
            ns = acc_min_s[c*DATA_W +: DATA_W];
            mu = acc_max_u[c*DATA_W +: DATA_W];
            nu = acc_min_u[c*DATA_W +: DATA_W];
            if (win_n == 0) begin
                ms = v; ns = v; mu = v; nu = v;
            end else begin
                if ($signed(v) > $signed(ms)) ms = v;
                if ($signed(v) < $signed(ns)) ns = v;
                if (v > mu) mu = v;
                if (v < nu) nu = v;
            end
            acc_max_s[c*DATA_W +: DATA_W] = ms;
            acc_min_s[c*DATA_W +: DATA_W] = ns;
            acc_max_u[c*DATA_W +: DATA_W] = mu;
            acc_min_u[c*DATA_W +: DATA_W] = nu;
        end
        win_n++;
        e.sample = w;
        e.pv     = (win_n == WINDOW_CONV);
        if (e.pv) begin
            pub_max_s = acc_max_s; pub_min_s = acc_min_s;
            pub_max_u = acc_max_u; pub_min_u = acc_min_u;
            win_n = 0;
        end
        e.pmax_s = pub_max_s; e.pmin_s = pub_min_s;
        e.pmax_u = pub_max_u; e.pmin_u = pub_min_u;
        exp_q.push_back(e);
    endfunction

    function automatic word_t rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: every SAMPLE_VALID pops one expected frame.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (PEAK_VALID) pv_count++;
            if (PEAK_VALID && !SAMPLE_VALID) begin
                checks++; failures++;
                $display("FAIL peak_valid_alone got PEAK_VALID=1 with SAMPLE_VALID=0 expected both together");
            end
            if (SAMPLE_VALID) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_sample got SAMPLE_VALID=1 expected none pending");
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (SAMPLE !== e.sample) begin
                        failures++;
                        $display("FAIL sample got %h expected %h", SAMPLE, e.sample);
                    end
                    checks++;
                    if (PEAK_VALID !== e.pv || u_peak_valid !== e.pv) begin
                        failures++;
                        $display("FAIL peak_valid got %b/%b expected %b", PEAK_VALID, u_peak_valid, e.pv);
                    end
                    checks++;
                    if (PEAK_MAX !== e.pmax_s || u_peak_max !== e.pmax_u) begin
                        failures++;
                        $display("FAIL peak_max got %h / %h expected %h / %h", PEAK_MAX, u_peak_max, e.pmax_s, e.pmax_u);
                    end
`ifdef ADC_PEAK_MIN_EN
                    checks++;
                    if (PEAK_MIN !== e.pmin_s || u_peak_min !== e.pmin_u) begin
                        failures++;
                        $display("FAIL peak_min got %h / %h expected %h / %h", PEAK_MIN, u_peak_min, e.pmin_s, e.pmin_u);
                    end
`endif
                end
            end
        end
    end

    // Runs n queued frames back to back, dropping PERFORM during the last one.
    task automatic run_burst(input int n);
        int seen  = 0;
        int guard = 0;
        @(negedge CLK);
        PERFORM = 1'b1;
        while (seen < n && guard < n * 80 + 50) begin
            @(negedge CLK);
            guard++;
            if (SAMPLE_VALID) seen++;
            if (PERFORM && seen == n - 1 && CNV) PERFORM = 1'b0;
        end
        PERFORM = 1'b0;
        checks++;
        if (seen != n) begin
            failures++;
            $display("FAIL burst_timeout got %0d samples expected %0d", seen, n);
        end
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_burst got %b expected 0", BUSY);
        end
        repeat (5) @(negedge CLK);
        win_n = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({CNV, SCK, SAMPLE_VALID, PEAK_VALID, BUSY} !== 5'b0 || SAMPLE !== '0 || PEAK_MAX !== '0) begin
            failures++;
            $display("FAIL reset_outputs got cnv=%b sck=%b sv=%b pv=%b busy=%b expected all 0", CNV, SCK, SAMPLE_VALID, PEAK_VALID, BUSY);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        PERFORM = 1'b1;
        #2;
        PERFORM = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || CNV !== 1'b0) begin
                failures++;
                $display("FAIL idle_glitch got busy=%b cnv=%b expected 0 0", BUSY, CNV);
            end
        end
    endtask

    task automatic test_timing();
        int first_cnv = -1, last_cnv = -1, cnv_hi = 0, sck_hi = 0, rises = 0;
        int first_rise = -1, last_rise = -1, sv_t = -1, sv_n = 0;
        logic prev_sck = 1'b0;
        queue_frame(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        PERFORM = 1'b1;
        for (int t = 0; t < 120; t++) begin
            @(negedge CLK);
            if (CNV) begin
                if (first_cnv < 0) first_cnv = t;
                last_cnv = t;
                cnv_hi++;
                PERFORM = 1'b0;
            end
            if (SCK) begin
                sck_hi++;
                if (!prev_sck) begin
                    rises++;
                    if (first_rise < 0) first_rise = t;
                    last_rise = t;
                end
            end
            prev_sck = SCK;
            if (SAMPLE_VALID) begin
                sv_n++;
                if (sv_t < 0) sv_t = t;
            end
        end
        checks++;
        if (cnv_hi != CNV_CYCLES || last_cnv - first_cnv != CNV_CYCLES - 1) begin
            failures++;
            $display("FAIL cnv_width got %0d cycles span %0d expected %0d", cnv_hi, last_cnv - first_cnv + 1, CNV_CYCLES);
        end
        checks++;
        if (first_rise - last_cnv - 2 != CONV_CYCLES) begin
            failures++;
            $display("FAIL conv_wait got %0d expected %0d", first_rise - last_cnv - 2, CONV_CYCLES);
        end
        checks++;
        if (rises != DATA_W || sck_hi != DATA_W || last_rise - first_rise != 2 * (DATA_W - 1)) begin
            failures++;
            $display("FAIL sck_pulses got rises=%0d high=%0d span=%0d expected %0d %0d %0d", rises, sck_hi, last_rise - first_rise, DATA_W, DATA_W, 2 * (DATA_W - 1));
        end
        checks++;
        if (sv_t - first_cnv != 58 || sv_n != 1) begin
            failures++;
            $display("FAIL sv_latency got %0d (pulses %0d) expected 58 (1)", sv_t - first_cnv, sv_n);
        end
        win_n = 0;
    endtask

    task automatic test_decode();
        word_t w;
        for (int i = 0; i < NUM_CH; i++) w[i*DATA_W +: DATA_W] = 16'h1000 * i + 16'h00A5;
        queue_frame(w);
        run_burst(1);
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (SAMPLE[i*DATA_W +: DATA_W] !== 16'(16'h1000 * i + 16'h00A5)) begin
                failures++;
                $display("FAIL decode_ch%0d got %h expected %h", i, SAMPLE[i*DATA_W +: DATA_W], 16'(16'h1000 * i + 16'h00A5));
            end
        end
        queue_frame(~w);
        queue_frame(rand_word());
        run_burst(2);
    endtask

    task automatic test_reset_mid_shift();
        int rises = 0;
        int guard = 0;
        logic prev_sck = 1'b0;
        PERFORM = 1'b1;
        while (rises < 5 && guard < 200) begin
            @(negedge CLK);
            guard++;
            if (SCK && !prev_sck) rises++;
            prev_sck = SCK;
        end
        RST = 1'b1;
        PERFORM = 1'b0;
        #1;
        checks++;
        if (rises != 5 || {CNV, SCK, BUSY, SAMPLE_VALID} !== 4'b0 || SAMPLE !== '0 || PEAK_MAX !== '0) begin
            failures++;
            $display("FAIL reset_mid_shift got rises=%0d cnv=%b sck=%b busy=%b sv=%b sample=%h expected 5 and zeros", rises, CNV, SCK, BUSY, SAMPLE_VALID, SAMPLE);
        end
        pub_max_s = '0; pub_min_s = '0; pub_max_u = '0; pub_min_u = '0;
        win_n = 0;
        @(negedge CLK);
        RST = 1'b0;
        rises = 0;
        repeat (80) begin
            @(negedge CLK);
            if (SAMPLE_VALID || BUSY) rises++;
        end
        checks++;
        if (rises != 0) begin
            failures++;
            $display("FAIL post_reset_activity got %0d active cycles expected 0", rises);
        end
    endtask

    task automatic test_peak_window();
        logic [DATA_W-1:0] seq[8] = '{16'd100, 16'd300, 16'd200, 16'd50, 16'd10, 16'd20, 16'd30, 16'd40};
        word_t w;
        int pv0 = pv_count;
        for (int k = 0; k < 4; k++) begin
            w = rand_word();
            w[DATA_W-1:0] = seq[k];
            queue_frame(w);
        end
        run_burst(4);
        checks++;
        if (PEAK_MAX[DATA_W-1:0] !== 16'd300 || pv_count != pv0 + 1) begin
            failures++;
            $display("FAIL window1_peak got %0d pv=%0d expected 300 pv=1", PEAK_MAX[DATA_W-1:0], pv_count - pv0);
        end
        for (int k = 4; k < 8; k++) begin
            w = rand_word();
            w[DATA_W-1:0] = seq[k];
            queue_frame(w);
        end
        run_burst(4);
        checks++;
        if (PEAK_MAX[DATA_W-1:0] !== 16'd40 || pv_count != pv0 + 2) begin
            failures++;
            $display("FAIL window2_peak got %0d pv=%0d expected 40 pv=2", PEAK_MAX[DATA_W-1:0], pv_count - pv0);
        end
    endtask

    task automatic test_signed();
        logic [DATA_W-1:0] vals[4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h7FFE};
        word_t w;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NUM_CH; c++) w[c*DATA_W +: DATA_W] = vals[(k + c) % 4];
            queue_frame(w);
        end
        run_burst(4);
        checks++;
        if (PEAK_MAX[DATA_W-1:0] !== 16'h7FFE) begin
            failures++;
            $display("FAIL signed_max got %h expected 7ffe", PEAK_MAX[DATA_W-1:0]);
        end
        checks++;
        if (u_peak_max[DATA_W-1:0] !== 16'hFFFF) begin
            failures++;
            $display("FAIL unsigned_max got %h expected ffff", u_peak_max[DATA_W-1:0]);
        end
`ifdef ADC_PEAK_MIN_EN
        checks++;
        if (PEAK_MIN[DATA_W-1:0] !== 16'h8000 || u_peak_min[DATA_W-1:0] !== 16'h0001) begin
            failures++;
            $display("FAIL min got %h / %h expected 8000 / 0001", PEAK_MIN[DATA_W-1:0], u_peak_min[DATA_W-1:0]);
        end
`endif
    endtask

    task automatic test_perform_drop();
        int pv0 = pv_count;
        for (int k = 0; k < 3; k++) queue_frame(rand_word());
        run_burst(3);
        checks++;
        if (pv_count != pv0 || PEAK_MAX !== pub_max_s) begin
            failures++;
            $display("FAIL partial_window got pv=%0d peak=%h expected pv=0 peak=%h", pv_count - pv0, PEAK_MAX, pub_max_s);
        end
        for (int k = 0; k < 4; k++) queue_frame(rand_word());
        run_burst(4);
        checks++;
        if (pv_count != pv0 + 1) begin
            failures++;
            $display("FAIL restart_window got pv=%0d expected 1", pv_count - pv0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_decode();
        test_reset_mid_shift();
        test_peak_window();
        test_signed();
        test_perform_drop();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_samples got %0d left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
